// File: rtl/msg_severity_collector.sv
`default_nettype none
// ============================================================================
// Module   : msg_severity_collector
// Purpose  : Sink for severity-tagged message events. Accepts one event per
//            cycle over valid/ready, keeps saturating WARN/ERROR counts,
//            buffers events in a small FIFO toward a log consumer and halts
//            intake on a FATAL event or when the error threshold is reached.
// Ports    : clk, rst_n (async, active-low)
//            ev_valid/ev_ready/ev_sev/ev_id      - event intake
//            log_valid/log_ready/log_sev/log_id  - FIFO head toward logger
//            warn_cnt, err_cnt                   - accepted WARN/ERROR counts
//            halted                              - intake stopped
//            clr                                 - clear counters / resume
// Options  : MSG_INFO_FILTER_EN - INFO events complete the handshake but are
//            not written into the FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module msg_severity_collector #(
  parameter int ID_W      = 8,
  parameter int CNT_W     = 16,
  parameter int DEPTH     = 4,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic [1:0]       ev_sev,
  input  logic [ID_W-1:0]  ev_id,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [1:0]       log_sev,
  output logic [ID_W-1:0]  log_id,
  output logic [CNT_W-1:0] warn_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             halted,
  input  logic             clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] SEV_INFO  = 2'd0;
  localparam logic [1:0] SEV_WARN  = 2'd1;
  localparam logic [1:0] SEV_ERROR = 2'd2;
  localparam logic [1:0] SEV_FATAL = 2'd3;

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(ERR_LIMIT);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [1:0]       sev_mem [DEPTH];
  logic [ID_W-1:0]  id_mem  [DEPTH];
  logic [CNT_W-1:0] warn_nx, err_nx;

  logic full, empty, accept, push, pop, clr_ok, logged, limit_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Ready depends only on the state register and the pointer registers.
  assign ev_ready  = (state == RUN) && !full;
  assign halted    = (state == HALT);
  assign log_valid = !empty;

  // Head is forced to zero when empty so the outputs read zero straight out
  // of reset without needing to reset the storage array.
  assign log_sev = empty ? 2'd0       : sev_mem[rd_ptr[AW-1:0]];
  assign log_id  = empty ? '0         : id_mem[rd_ptr[AW-1:0]];

  assign accept = ev_valid && ev_ready;
  assign pop    = log_valid && log_ready;

`ifdef MSG_INFO_FILTER_EN
  assign logged = (ev_sev != SEV_INFO);
`else
  assign logged = 1'b1;
`endif

  assign push = accept && logged;

  // A clear in HALT only counts once the FIFO has fully drained.
  assign clr_ok = clr && ((state == RUN) || empty);

  always_comb begin
    warn_nx   = clr_ok ? '0 : warn_cnt;
    err_nx    = clr_ok ? '0 : err_cnt;
    limit_hit = 1'b0;
    state_nx  = state;
    // Clear is applied before the increment of a same-cycle accept.
    if (accept && (ev_sev == SEV_WARN))  warn_nx = sat_inc(warn_nx);
    if (accept && (ev_sev == SEV_ERROR)) err_nx  = sat_inc(err_nx);
    if ((ERR_LIMIT != 0) && (err_nx >= LIMIT_C)) limit_hit = 1'b1;
    case (state)
      RUN: begin
        if (accept && ((ev_sev == SEV_FATAL) ||
                       ((ev_sev == SEV_ERROR) && limit_hit)))
          state_nx = HALT;
      end
      HALT: begin
        if (clr_ok) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      warn_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nx;
      warn_cnt <= warn_nx;
      err_cnt  <= err_nx;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (push) begin
      sev_mem[wr_ptr[AW-1:0]] <= ev_sev;
      id_mem[wr_ptr[AW-1:0]]  <= ev_id;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_severity_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_msg_severity_collector
// Purpose  : Directed, table-driven bench for msg_severity_collector, plus a
//            second narrow-counter instance for saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_severity_collector;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance
  logic       ev_valid, log_ready, clr;
  logic [1:0] ev_sev;
  logic [7:0] ev_id;
  logic       ev_ready, log_valid, halted;
  logic [1:0] log_sev;
  logic [7:0] log_id;
  logic [15:0] warn_cnt, err_cnt;

  msg_severity_collector #(.ID_W(8), .CNT_W(16), .DEPTH(4), .ERR_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_sev(ev_sev), .ev_id(ev_id),
    .log_valid(log_valid), .log_ready(log_ready), .log_sev(log_sev), .log_id(log_id),
    .warn_cnt(warn_cnt), .err_cnt(err_cnt), .halted(halted), .clr(clr)
  );

  // Saturation instance: 2-bit counters, threshold disabled
  logic       s_valid, s_ready, s_lvalid, s_halted;
  logic [1:0] s_sev, s_lsev, s_warn, s_err;
  logic [7:0] s_lid;

  msg_severity_collector #(.ID_W(8), .CNT_W(2), .DEPTH(4), .ERR_LIMIT(0)) sat_dut (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(s_valid), .ev_ready(s_ready), .ev_sev(s_sev), .ev_id(8'h00),
    .log_valid(s_lvalid), .log_ready(1'b1), .log_sev(s_lsev), .log_id(s_lid),
    .warn_cnt(s_warn), .err_cnt(s_err), .halted(s_halted), .clr(1'b0)
  );

  typedef struct {
    logic        v;
    logic [1:0]  sev;
    logic [7:0]  id;
    logic        lr;
    logic        clr;
    logic        e_rdy;
    logic        e_lv;
    logic [1:0]  e_lsev;
    logic [7:0]  e_lid;
    logic [15:0] e_wc;
    logic [15:0] e_ec;
    logic        e_h;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  task automatic add(input logic v, input logic [1:0] sev, input logic [7:0] id,
                     input logic lr, input logic c, input logic rdy, input logic lv,
                     input logic [1:0] lsev, input logic [7:0] lid,
                     input logic [15:0] wc, input logic [15:0] ec, input logic h);
    vec_t t;
    t = '{v, sev, id, lr, c, rdy, lv, lsev, lid, wc, ec, h};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic rdy, input logic lv,
                       input logic [1:0] lsev, input logic [7:0] lid,
                       input logic [15:0] wc, input logic [15:0] ec, input logic h);
    tests++;
    if (ev_ready !== rdy || log_valid !== lv || log_sev !== lsev || log_id !== lid ||
        warn_cnt !== wc || err_cnt !== ec || halted !== h) begin
      fails++;
      $display("FAIL %s: got rdy=%b lv=%b sev=%0d id=%h wc=%0d ec=%0d h=%b, want rdy=%b lv=%b sev=%0d id=%h wc=%0d ec=%0d h=%b",
               name, ev_ready, log_valid, log_sev, log_id, warn_cnt, err_cnt, halted,
               rdy, lv, lsev, lid, wc, ec, h);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ev_valid = 0; ev_sev = 0; ev_id = 0; log_ready = 0; clr = 0;
    s_valid = 0; s_sev = 0;

    //   v sev id    lr clr | rdy lv lsev lid   wc ec h
    // First WARN with consumer ready
    add(1, 1, 8'h10, 1, 0,   1, 1, 1, 8'h10, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0,   1, 0, 0, 8'h00, 1, 0, 0);
`ifndef MSG_INFO_FILTER_EN
    // Fill with INFO while blocked: 4 accepted, 5th refused
    add(1, 0, 8'h01, 0, 0,   1, 1, 0, 8'h01, 1, 0, 0);
    add(1, 0, 8'h02, 0, 0,   1, 1, 0, 8'h01, 1, 0, 0);
    add(1, 0, 8'h03, 0, 0,   1, 1, 0, 8'h01, 1, 0, 0);
    add(1, 0, 8'h04, 0, 0,   0, 1, 0, 8'h01, 1, 0, 0);
    add(1, 0, 8'h05, 0, 0,   0, 1, 0, 8'h01, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0,   1, 1, 0, 8'h02, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0,   1, 1, 0, 8'h03, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0,   1, 1, 0, 8'h04, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0,   1, 0, 0, 8'h00, 1, 0, 0);
`else
    // INFO is accepted but never reaches the log
    add(1, 0, 8'h01, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0);
    add(1, 0, 8'h02, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0);
    add(1, 0, 8'h03, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0);
    add(1, 0, 8'h04, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0);
    add(1, 0, 8'h05, 0, 0,   1, 0, 0, 8'h00, 1, 0, 0);
`endif
    // Three ERRORs reach the threshold
    add(1, 2, 8'h21, 1, 0,   1, 1, 2, 8'h21, 1, 1, 0);
    add(1, 2, 8'h22, 1, 0,   1, 1, 2, 8'h22, 1, 2, 0);
    add(1, 2, 8'h23, 0, 0,   0, 1, 2, 8'h22, 1, 3, 1);
    add(1, 2, 8'h24, 0, 1,   0, 1, 2, 8'h22, 1, 3, 1);  // clr ignored, not empty
    add(0, 0, 8'h00, 1, 0,   0, 1, 2, 8'h23, 1, 3, 1);
    add(0, 0, 8'h00, 1, 0,   0, 0, 0, 8'h00, 1, 3, 1);
    add(0, 0, 8'h00, 1, 1,   1, 0, 0, 8'h00, 0, 0, 0);  // resume, counters cleared
    // FATAL with FIFO non-empty
    add(1, 1, 8'h31, 0, 0,   1, 1, 1, 8'h31, 1, 0, 0);
    add(1, 3, 8'h7F, 0, 0,   0, 1, 1, 8'h31, 1, 0, 1);
    add(0, 0, 8'h00, 1, 0,   0, 1, 3, 8'h7F, 1, 0, 1);
    add(0, 0, 8'h00, 0, 1,   0, 1, 3, 8'h7F, 1, 0, 1);  // early clr ignored
    add(0, 0, 8'h00, 1, 0,   0, 0, 0, 8'h00, 1, 0, 1);
    add(0, 0, 8'h00, 0, 1,   1, 0, 0, 8'h00, 0, 0, 0);
    // clr in RUN together with an accept: clear first, then increment
    add(1, 1, 8'h41, 1, 0,   1, 1, 1, 8'h41, 1, 0, 0);
    add(1, 1, 8'h42, 1, 0,   1, 1, 1, 8'h42, 2, 0, 0);
    add(1, 1, 8'h43, 1, 1,   1, 1, 1, 8'h43, 1, 0, 0);
    add(1, 2, 8'h44, 1, 0,   1, 1, 2, 8'h44, 1, 1, 0);
    add(0, 0, 8'h00, 1, 0,   1, 0, 0, 8'h00, 1, 1, 0);
`ifdef MSG_INFO_FILTER_EN
    // INFO then ERROR: single log entry with sev 2
    add(1, 0, 8'h51, 0, 0,   1, 0, 0, 8'h00, 1, 1, 0);
    add(1, 2, 8'h52, 0, 0,   1, 1, 2, 8'h52, 1, 2, 0);
    add(0, 0, 8'h00, 1, 0,   1, 0, 0, 8'h00, 1, 2, 0);
`else
    add(1, 0, 8'h51, 0, 0,   1, 1, 0, 8'h51, 1, 1, 0);
    add(1, 2, 8'h52, 0, 0,   1, 1, 0, 8'h51, 1, 2, 0);
    add(0, 0, 8'h00, 1, 0,   1, 1, 2, 8'h52, 1, 2, 0);
    add(0, 0, 8'h00, 1, 0,   1, 0, 0, 8'h00, 1, 2, 0);
`endif

    repeat (2) @(posedge clk);
    #1 check("reset", 1, 1'b0, 2'd0, 8'h00, 16'd0, 16'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      ev_valid = vecs[i].v; ev_sev = vecs[i].sev; ev_id = vecs[i].id;
      log_ready = vecs[i].lr; clr = vecs[i].clr;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_lv, vecs[i].e_lsev,
               vecs[i].e_lid, vecs[i].e_wc, vecs[i].e_ec, vecs[i].e_h);
    end

    // Asynchronous reset mid-operation with an entry buffered
    @(negedge clk);
    ev_valid = 1; ev_sev = 2'd1; ev_id = 8'h61; log_ready = 0; clr = 0;
    @(posedge clk);
    #1 check("pre_async_rst", 1, 1'b1, 2'd1, 8'h61, 16'd2, 16'd2, 1'b0);
    @(negedge clk) ev_valid = 0;
    #2 rst_n = 1'b0;
    #1 check("async_rst", 1, 1'b0, 2'd0, 8'h00, 16'd0, 16'd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); s_valid = 1; s_sev = 2'd1;
      @(posedge clk);
      #1 tests++;
      if (s_warn !== ((i >= 2) ? 2'd3 : 2'(i + 1))) begin
        fails++;
        $display("FAIL sat_warn%0d: got %0d want %0d", i, s_warn, (i >= 2) ? 3 : i + 1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); s_valid = 1; s_sev = 2'd2;
      @(posedge clk);
      #1 tests++;
      if (s_err !== ((i >= 2) ? 2'd3 : 2'(i + 1)) || s_halted !== 1'b0 || s_warn !== 2'd3) begin
        fails++;
        $display("FAIL sat_err%0d: got err=%0d h=%b w=%0d want err=%0d h=0 w=3",
                 i, s_err, s_halted, s_warn, (i >= 2) ? 3 : i + 1);
      end
    end
    @(negedge clk) s_valid = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
